// File: rtl/mul_cell_share_ctrl.sv
// Shares one registered three-partial-product multiplier cell between two 32x32 requesters.
// Define MUL_CELL_SHARE_RR_EN for round-robin arbitration; otherwise port A has fixed priority.
module mul_cell_share_ctrl #(
    parameter int MUL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        a_req_valid,
    output logic        a_req_ready,
    input  logic [31:0] a_src1,
    input  logic [31:0] a_src2,
    output logic        a_rsp_valid,
    input  logic        a_rsp_ready,
    input  logic        b_req_valid,
    output logic        b_req_ready,
    input  logic [31:0] b_src1,
    input  logic [31:0] b_src2,
    output logic        b_rsp_valid,
    input  logic        b_rsp_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] mul_src1,
    output logic [31:0] mul_src2,
    output logic        mul_en,
    input  logic [31:0] mul_p1,
    input  logic [31:0] mul_p2,
    input  logic [31:0] mul_p3,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] LAT_M1 = 2'(MUL_LATENCY - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_nxt;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [31:0] r_rsp;
    logic        r_gnt_b;
    logic        w_gnt_b;
    logic        w_accept;
    logic        w_fold_en;
    logic        w_rsp_ready;

    // Low 32 bits of src1*src2; the high halves of p2/p3 fall off the shift.
    function automatic logic [31:0] fold_partials(input logic [31:0] p1,
                                                  input logic [31:0] p2,
                                                  input logic [31:0] p3);
        return p1 + ((p2 + p3) << 16);
    endfunction

`ifdef MUL_CELL_SHARE_RR_EN
    logic r_last_b;

    always_comb begin
        if (a_req_valid && b_req_valid) begin
            w_gnt_b = !r_last_b;
        end else begin
            w_gnt_b = b_req_valid;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_b <= 1'b1;
        end else if (w_accept) begin
            r_last_b <= w_gnt_b;
        end
    end
`else
    always_comb begin
        w_gnt_b = !a_req_valid;
    end
`endif

    // Ready is also gated by reset so every output reads 0 while reset is held.
    assign w_accept    = (r_state == S_IDLE) && (a_req_valid || b_req_valid) && reset_n;
    assign a_req_ready = w_accept && !w_gnt_b;
    assign b_req_ready = w_accept && w_gnt_b;

    assign w_fold_en   = (r_state == S_WAIT) && (r_cnt == 2'd0);
    assign w_rsp_ready = r_gnt_b ? b_rsp_ready : a_rsp_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        mul_en      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mul_en      = 1'b1;
                w_cnt_nxt   = LAT_M1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt != 2'd0) begin
                    mul_en    = 1'b1;
                    w_cnt_nxt = r_cnt - 2'd1;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (w_rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Operands and grant are captured on the accept edge and held for the whole operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op1   <= 32'd0;
            r_op2   <= 32'd0;
            r_gnt_b <= 1'b0;
        end else if (w_accept) begin
            r_op1   <= w_gnt_b ? b_src1 : a_src1;
            r_op2   <= w_gnt_b ? b_src2 : a_src2;
            r_gnt_b <= w_gnt_b;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp <= 32'd0;
        end else if (w_fold_en) begin
            r_rsp <= fold_partials(mul_p1, mul_p2, mul_p3);
        end
    end

    assign mul_src1    = r_op1;
    assign mul_src2    = r_op2;
    assign rsp_data    = r_rsp;
    assign a_rsp_valid = (r_state == S_RESP) && !r_gnt_b;
    assign b_rsp_valid = (r_state == S_RESP) && r_gnt_b;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: doc/mul_cell_share_ctrl.md
Name: mul_cell_share_ctrl

Overview:
- Arbitrates two 32x32 multiply requesters (port A, port B) onto one shared three-partial-product multiplier cell.
- The cell provides registered, enable-gated products: p1 = src1[15:0]*src2[15:0], p2 = src1[15:0]*src2[31:16], p3 = src1[31:16]*src2[15:0].
- The block sequences the operand issue and waits out the cell latency.
- It then folds the partials into the low 32 product bits and returns the result to the granted requester over a valid/ready response channel.

Parameters:
- MUL_LATENCY, 1, clock edges from the first mul_en-high cycle until mul_p1..p3 are valid; legal 1..4.

Ports:
- clk  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- a_req_valid  in  1  port A request valid
- a_req_ready  out  1  port A request accepted this cycle
- a_src1  in  32  port A multiplicand
- a_src2  in  32  port A multiplier
- a_rsp_valid  out  1  port A result valid
- a_rsp_ready  in  1  port A result consumed
- b_req_valid, b_req_ready, b_src1, b_src2, b_rsp_valid, b_rsp_ready: same as port A, for port B
- rsp_data  out  32  low 32 bits of product; shared by both ports, qualified by x_rsp_valid
- mul_src1  out  32  operand to cell src1
- mul_src2  out  32  operand to cell src2
- mul_en  out  1  cell clock enable
- mul_p1, mul_p2, mul_p3  in  32 each  cell partial products
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock/reset: one clock (clk). Reset is asynchronous, active-low (reset_n).
- Reset values: all outputs 0; state IDLE; operand and result registers 0; last-grant = B.
- IDLE:
  - If any req_valid, grant per the arbitration rule and pulse that port's req_ready for 1 cycle (combinational from req_valid and state).
  - Latch the granted src1/src2 into operand registers and the grant id into a register; go to ISSUE.
  - The non-granted port's ready stays 0; its request stays pending.
- ISSUE:
  - mul_src1/mul_src2 are driven from the operand registers in every state; they are 0 only after reset.
  - mul_en = 1. Load the latency counter with MUL_LATENCY-1; go to WAIT.
- WAIT:
  - mul_en stays 1 while counter != 0; decrement each cycle.
  - When counter == 0, mul_en = 0 and partials are valid.
  - Register rsp_data = (mul_p1 + ((mul_p2 + mul_p3) << 16)) mod 2^32; go to RESP.
  - Bits of p2/p3 above 15 are discarded by the shift/truncation.
- RESP:
  - The granted port's rsp_valid = 1 and rsp_data is held stable until that port's rsp_ready = 1.
  - On that cycle go to IDLE. New requests are not accepted in the same cycle.
- Latency: accept edge to rsp_valid = MUL_LATENCY + 2 cycles (3 at the default). Throughput: one op per MUL_LATENCY + 3 cycles with rsp_ready tied high.
- Only one operation is outstanding; rsp_valid is never high on both ports at once.
- Arbitration (default): fixed priority, A over B when both are valid in IDLE.
- Request rule: requesters must hold src stable while req_valid && !req_ready. Dropping req_valid before grant is legal, and no grant results.
- Response rule: rsp_ready asserted while rsp_valid = 0 is ignored.
- Reset mid-operation (any state): immediate return to reset values. The in-flight result is lost and no response is issued after reset release.
- A new request arriving while busy is not accepted; ready = 0 until IDLE.

Optional Feature:
- Macro: MUL_CELL_SHARE_RR_EN.
- Defined: round-robin arbitration. On a simultaneous request, grant the port not granted last; last-grant updates on every grant.
- Undefined: fixed priority A over B; the last-grant register is not built.

Test Plan:
- A only, a_src1 = 3, a_src2 = 5, MUL_LATENCY = 1 -> a_req_ready pulse at T0; a_rsp_valid at T0+3; rsp_data = 0x0000000F; b_rsp_valid stays 0.
- B only, 0xFFFFFFFF * 0xFFFFFFFF -> rsp_data = 0x00000001; then 0x00012345 * 0x00000100 -> rsp_data = 0x01234500.
- A and B valid in the same IDLE cycle, A = 2*2, B = 7*6 -> A served first (rsp_data 4), then B (rsp_data 42). With MUL_CELL_SHARE_RR_EN and a repeated collision, the second collision grants B first.
- Response backpressure: hold a_rsp_ready = 0 for 10 cycles -> a_rsp_valid and rsp_data stable, busy = 1, b_req_ready = 0 throughout; release -> IDLE the next cycle.
- MUL_LATENCY = 3 -> mul_en high for exactly 3 cycles per op; result at accept+5 cycles; 0x00010001 * 0x00010001 -> rsp_data = 0x00020001.
- reset_n low during WAIT -> all outputs 0 asynchronously; after release, no rsp_valid until a new request; a fresh 3*5 returns 15.
